nand_bank_power_monitor: RTL and testbench

Clocked, parametrised bank of WIDTH registered 2-input NAND channels with built-in switching-activity measurement. It counts output transitions over a programmable window and accumulates switching charge as transitions × E_PER_TOGGLE, scaled to the existing gate power-estimate figure (0.05 nF × 3.3 V = 0.165 → 165 in 1e-3 nF·V units). It raises a sticky threshold alarm. It is the synthesizable, multi-channel successor to the single combinational NAND gate model, for use in the logic-family power test benches.

---
 rtl/nand_bank_power_monitor.sv | 182 ++++++++++++++++++
 tb/tb_nand_bank_power_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nand_bank_power_monitor.sv
// nand_bank_power_monitor
// Bank of WIDTH registered 2-input NAND channels with a windowed
// switching-activity monitor. Output transitions are counted over a
// programmable window and converted to switching charge at E_PER_TOGGLE
// units per transition (0.05 nF x 3.3 V -> 165 in 1e-3 nF*V units).
// Both accumulators saturate, and a sticky alarm flags when the window
// energy reaches a programmable threshold.
module nand_bank_power_monitor #(
  parameter int WIDTH        = 4,
  parameter int CNT_W        = 16,
  parameter int ENERGY_W     = 32,
  parameter int WIN_W        = 16,
  parameter int E_PER_TOGGLE = 165
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                en,
  output logic [WIDTH-1:0]    y,
  input  logic                start,
  input  logic [WIN_W-1:0]    win_len,
  output logic                busy,
  output logic [CNT_W-1:0]    toggles,
  output logic [ENERGY_W-1:0] energy,
  input  logic [ENERGY_W-1:0] alarm_thr,
  output logic                alarm,
  output logic                done_valid,
  input  logic                done_ack
);

  // Enough bits to hold a transition count of 0..WIDTH in one cycle.
  localparam int TOG_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Number of set bits in a channel-wide vector.
  function automatic logic [TOG_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [TOG_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + TOG_W'(v[i]);
    end
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    y_q, y_d;
  logic [CNT_W-1:0]    toggles_q, toggles_d;
  logic [ENERGY_W-1:0] energy_q, energy_d;
  logic [WIN_W-1:0]    remaining_q, remaining_d;
  logic                alarm_q, alarm_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [TOG_W-1:0]    tog_s;
  logic [CNT_W:0]      tog_sum_s;
  logic [ENERGY_W-1:0] prod_s;
  logic [ENERGY_W:0]   energy_sum_s;
  logic [CNT_W-1:0]    toggles_sat_s;
  logic [ENERGY_W-1:0] energy_sat_s;

  // Gate bank next value and saturating accumulator arithmetic.
  always_comb begin
    y_d = y_q;
    if (en) begin
      y_d = ~(a & b);
    end else begin
      y_d = y_q;
    end

    // A held bank produces no transitions because y_d equals y_q.
    tog_s = popcount(y_d ^ y_q);

    tog_sum_s = {1'b0, toggles_q} + (CNT_W + 1)'(tog_s);
    if (tog_sum_s[CNT_W]) begin
      toggles_sat_s = '1;
    end else begin
      toggles_sat_s = tog_sum_s[CNT_W-1:0];
    end

    // Product is formed at full accumulator width before the add.
    prod_s       = ENERGY_W'(tog_s) * ENERGY_W'(E_PER_TOGGLE);
    energy_sum_s = {1'b0, energy_q} + {1'b0, prod_s};
    if (energy_sum_s[ENERGY_W]) begin
      energy_sat_s = '1;
    end else begin
      energy_sat_s = energy_sum_s[ENERGY_W-1:0];
    end
  end

  // Measurement FSM: next state, accumulators, alarm and status flags.
  always_comb begin
    state_d     = state_q;
    toggles_d   = toggles_q;
    energy_d    = energy_q;
    remaining_d = remaining_q;
    alarm_d     = alarm_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (win_len != '0)) begin
          state_d     = ST_MEASURE;
          toggles_d   = '0;
          energy_d    = '0;
          alarm_d     = 1'b0;
          remaining_d = win_len;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MEASURE: begin
        toggles_d   = toggles_sat_s;
        energy_d    = energy_sat_s;
        remaining_d = remaining_q - WIN_W'(1);
        // Alarm looks at the energy value being written this edge.
        if ((alarm_thr != '0) && (energy_sat_s >= alarm_thr)) begin
          alarm_d = 1'b1;
        end else begin
          alarm_d = alarm_q;
        end
        if (remaining_q == WIN_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MEASURE;
        end
      end

      ST_DONE: begin
        // start is deliberately ignored here, even alongside done_ack.
        if (done_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_MEASURE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      y_q         <= '1;
      toggles_q   <= '0;
      energy_q    <= '0;
      remaining_q <= '0;
      alarm_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      toggles_q   <= toggles_d;
      energy_q    <= energy_d;
      remaining_q <= remaining_d;
      alarm_q     <= alarm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign y          = y_q;
  assign toggles    = toggles_q;
  assign energy     = energy_q;
  assign alarm      = alarm_q;
  assign busy       = busy_q;
  assign done_valid = done_q;

endmodule

// File: tb/tb_nand_bank_power_monitor.sv
// Self-checking bench for nand_bank_power_monitor. A reference model of
// the monitor predicts every output each cycle; predictions are queued
// when stimulus is applied and compared once the DUT has clocked. A second
// instance with CNT_W = 4 exercises toggle-counter saturation.
module tb_nand_bank_power_monitor;

  logic        clk;
  logic        reset;
  logic [3:0]  a, b;
  logic        en;
  logic        start;
  logic [15:0] win_len;
  logic [31:0] alarm_thr;
  logic        done_ack;

  logic [3:0]  y, y_s;
  logic        busy, busy_s;
  logic [15:0] toggles;
  logic [3:0]  toggles_s;
  logic [31:0] energy, energy_s;
  logic        alarm, alarm_s;
  logic        done_valid, done_valid_s;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic       alarm;
    longint     tog;
    longint     tog4;
    longint     energy;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  int         m_st;   // 0 idle, 1 measure, 2 done
  logic [3:0] m_y;
  longint     m_tg, m_tg4, m_e, m_rem;
  logic       m_al;

  nand_bank_power_monitor dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .en(en), .y(y),
    .start(start), .win_len(win_len), .busy(busy), .toggles(toggles),
    .energy(energy), .alarm_thr(alarm_thr), .alarm(alarm),
    .done_valid(done_valid), .done_ack(done_ack)
  );

  nand_bank_power_monitor #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .a(a), .b(b), .en(en), .y(y_s),
    .start(start), .win_len(win_len), .busy(busy_s), .toggles(toggles_s),
    .energy(energy_s), .alarm_thr(alarm_thr), .alarm(alarm_s),
    .done_valid(done_valid_s), .done_ack(done_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one rising edge using current inputs.
  task automatic model_edge();
    logic [3:0] yn;
    longint     t;
    if (reset) begin
      m_st = 0; m_y = 4'hF; m_tg = 0; m_tg4 = 0; m_e = 0; m_al = 1'b0; m_rem = 0;
    end else begin
      yn = en ? ~(a & b) : m_y;
      t  = $countones(yn ^ m_y);
      case (m_st)
        0: begin
          if (start && (win_len != 16'd0)) begin
            m_st = 1; m_tg = 0; m_tg4 = 0; m_e = 0; m_al = 1'b0; m_rem = win_len;
          end
        end
        1: begin
          m_tg  = (m_tg + t > 65535) ? 65535 : m_tg + t;
          m_tg4 = (m_tg4 + t > 15) ? 15 : m_tg4 + t;
          m_e   = (m_e + t * 165 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_e + t * 165;
          if ((alarm_thr != 32'd0) && (m_e >= alarm_thr)) m_al = 1'b1;
          m_rem = m_rem - 1;
          if (m_rem == 0) m_st = 2;
        end
        default: begin
          if (done_ack) m_st = 0;
        end
      endcase
      m_y = yn;
    end
  endtask

  // Apply one cycle: predict, push, clock, then pop and compare.
  task automatic cyc();
    exp_t e;
    model_edge();
    e.y = m_y; e.busy = (m_st == 1); e.done = (m_st == 2); e.alarm = m_al;
    e.tog = m_tg; e.tog4 = m_tg4; e.energy = m_e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("y", y, e.y);
    chk("busy", busy, e.busy);
    chk("done_valid", done_valid, e.done);
    chk("alarm", alarm, e.alarm);
    chk("toggles", toggles, e.tog);
    chk("energy", energy, e.energy);
    chk("toggles_sat", toggles_s, e.tog4);
    chk("energy_sat", energy_s, e.energy);
  endtask

  // Accepted-start edge plus len counted edges with b alternating F,0.
  task automatic run_window(input int len, input logic en_v);
    a = 4'hF; en = en_v; b = 4'h0; start = 1'b1; win_len = 16'(len);
    cyc();
    start = 1'b0;
    for (int i = 1; i <= len; i++) begin
      b = (i % 2 == 1) ? 4'hF : 4'h0;
      cyc();
    end
    b = 4'h0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b1; a = 4'h0; b = 4'h0; en = 1'b0; start = 1'b0;
    win_len = 16'd0; alarm_thr = 32'd0; done_ack = 1'b0;

    // Reset for two cycles.
    cyc(); cyc();
    chk("rst_y", y, 4'hF);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Window count: 4 edges, 16 transitions, 2640 energy units.
    run_window(4, 1'b1);
    chk("win_toggles", toggles, 16);
    chk("win_energy", energy, 2640);
    chk("win_done", done_valid, 1'b1);
    chk("sat_toggles", toggles_s, 15);
    chk("sat_energy", energy_s, 2640);
    cyc();
    done_ack = 1'b1; cyc(); done_ack = 1'b0;
    cyc();
    chk("held_toggles", toggles, 16);
    chk("held_done", done_valid, 1'b0);

    // Enable hold: bank frozen, nothing counted.
    run_window(4, 1'b0);
    chk("hold_y", y, 4'hF);
    chk("hold_toggles", toggles, 0);
    chk("hold_energy", energy, 0);
    done_ack = 1'b1; cyc(); done_ack = 1'b0;

    // Alarm at 1000: 660 after E1 without alarm, 1320 after E2 with alarm.
    alarm_thr = 32'd1000;
    a = 4'hF; en = 1'b1; b = 4'h0; start = 1'b1; win_len = 16'd4;
    cyc();
    start = 1'b0;
    b = 4'hF; cyc();
    chk("alm_e1_energy", energy, 660);
    chk("alm_e1_alarm", alarm, 1'b0);
    b = 4'h0; cyc();
    chk("alm_e2_energy", energy, 1320);
    chk("alm_e2_alarm", alarm, 1'b1);
    b = 4'hF; cyc();
    b = 4'h0; cyc();
    cyc();
    done_ack = 1'b1; cyc(); done_ack = 1'b0;
    chk("alm_idle_sticky", alarm, 1'b1);
    alarm_thr = 32'd0;
    start = 1'b1; win_len = 16'd2; cyc(); start = 1'b0;
    chk("alm_cleared", alarm, 1'b0);
    cyc(); cyc();
    done_ack = 1'b1; cyc(); done_ack = 1'b0;

    // start with win_len = 0 is ignored.
    start = 1'b1; win_len = 16'd0; cyc(); start = 1'b0;
    chk("zero_len_busy", busy, 1'b0);
    cyc();

    // start during MEASURE does not change the window length.
    start = 1'b1; win_len = 16'd4; cyc();
    win_len = 16'd9; cyc(); cyc(); start = 1'b0; cyc(); cyc();
    chk("mid_start_done", done_valid, 1'b1);

    // start together with done_ack in DONE returns to IDLE only.
    start = 1'b1; done_ack = 1'b1; win_len = 16'd3; cyc();
    start = 1'b0; done_ack = 1'b0;
    chk("ack_start_busy", busy, 1'b0);
    cyc();

    // Reset at E2 of a 4-cycle window discards the partial result.
    run_window(0, 1'b1);
    start = 1'b1; win_len = 16'd4; b = 4'h0; cyc(); start = 1'b0;
    b = 4'hF; cyc();
    reset = 1'b1; b = 4'h0; cyc(); reset = 1'b0;
    chk("mid_rst_toggles", toggles, 0);
    cyc(); cyc(); cyc();
    chk("mid_rst_done", done_valid, 1'b0);

    // Random traffic checked against the model.
    for (int w = 0; w < 6; w++) begin
      alarm_thr = (w % 2 == 0) ? 32'd0 : 32'($urandom_range(200, 3000));
      start = 1'b1; win_len = 16'($urandom_range(1, 8));
      for (int c = 0; c < 14; c++) begin
        a = 4'($urandom); b = 4'($urandom); en = 1'($urandom);
        done_ack = (c > 10);
        cyc();
        start = 1'($urandom_range(0, 3) == 0);
        win_len = 16'($urandom_range(0, 5));
      end
      start = 1'b0; done_ack = 1'b1; cyc(); done_ack = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
